bfs_solve_ctrl: RTL and testbench

//  Top-level sequencer for the maze solver. It runs one solve per request:
//  the BFS distance fill first, then the distance-table backtrace.

---
 rtl/bfs_solve_ctrl.sv | 142 ++++++++++++++
 tb/tb_bfs_solve_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfs_solve_ctrl.sv
// rtl/bfs_solve_ctrl.sv - maze solver sequencer: BFS fill then backtrace, with timeouts
//
// Runs one solve per accepted start: FILL (fill engine enabled) then BT
// (backtrace engine enabled while the fill engine keeps holding its distance
// table), then a single CLR cycle with both enables low before returning to
// IDLE and pulsing done. Status, path length and per-phase cycle counts are
// latched for the host and held until the next accepted start.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   start, abort                  host request / cancel
//   busy, done, status            host status (done is a 1-cycle pulse)
//   result_len                    path length when status==OK, else 0
//   fill_cycles, bt_cycles        saturating per-phase cycle counts
//   fill_en, fill_done, fill_reached              BFS fill engine handshake
//   bt_en, bt_done, bt_no_path, bt_path_length    backtrace engine handshake

module bfs_solve_ctrl #(
  parameter int CNT_W    = 16,
  parameter int FILL_TMO = 2048,
  parameter int BT_TMO   = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [6:0]       result_len,
  output logic [CNT_W-1:0] fill_cycles,
  output logic [CNT_W-1:0] bt_cycles,
  output logic             fill_en,
  input  logic             fill_done,
  input  logic             fill_reached,
  output logic             bt_en,
  input  logic             bt_done,
  input  logic             bt_no_path,
  input  logic [6:0]       bt_path_length
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BT, S_CLR} state_t;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_NO_PATH  = 3'd1;
  localparam logic [2:0] ST_TMO_FILL = 3'd2;
  localparam logic [2:0] ST_TMO_BT   = 3'd3;
  localparam logic [2:0] ST_ABORTED  = 3'd4;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TMO - 1);
  localparam logic [CNT_W-1:0] BT_LAST   = CNT_W'(BT_TMO - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment; the same value is both the next counter value and
  // the "cycles spent" figure latched when a phase ends.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      result_len  <= '0;
      fill_cycles <= '0;
      bt_cycles   <= '0;
      fill_en     <= 1'b0;
      bt_en       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FILL;
            fill_en     <= 1'b1;
            busy        <= 1'b1;
            cnt         <= '0;
            status      <= ST_OK;
            result_len  <= '0;
            fill_cycles <= '0;
            bt_cycles   <= '0;
          end
        end

        S_FILL: begin
          cnt <= cnt_inc;
          if (fill_done && fill_reached) begin
            // fill_en stays high so the distance table is held for the backtrace
            state       <= S_BT;
            bt_en       <= 1'b1;
            fill_cycles <= cnt_inc;
            cnt         <= '0;
          end else if (fill_done || abort || cnt == FILL_LAST) begin
            state       <= S_CLR;
            fill_en     <= 1'b0;
            fill_cycles <= cnt_inc;
            cnt         <= '0;
            if (fill_done)  status <= ST_NO_PATH;
            else if (abort) status <= ST_ABORTED;
            else            status <= ST_TMO_FILL;
          end
        end

        S_BT: begin
          cnt <= cnt_inc;
          if (bt_done || abort || cnt == BT_LAST) begin
            state     <= S_CLR;
            fill_en   <= 1'b0;
            bt_en     <= 1'b0;
            bt_cycles <= cnt_inc;
            cnt       <= '0;
            if (bt_done && !bt_no_path) begin
              status     <= ST_OK;
              result_len <= bt_path_length;
            end else if (bt_done) begin
              status     <= ST_NO_PATH;
              result_len <= '0;
            end else if (abort) begin
              status <= ST_ABORTED;
            end else begin
              status <= ST_TMO_BT;
            end
          end
        end

        S_CLR: begin
          // one cycle with both enables low lets both engines fall back to idle
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfs_solve_ctrl.sv
// tb/tb_bfs_solve_ctrl.sv - self-checking bench for bfs_solve_ctrl

module tb_bfs_solve_ctrl;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_t = 1'b0, abort = 1'b0;
  logic fill_done = 1'b0, fill_reached = 1'b0, bt_done = 1'b0, bt_no_path = 1'b0;
  logic [6:0] bt_path_length = '0;

  logic busy, done, fill_en, bt_en;
  logic [2:0] status;
  logic [6:0] result_len;
  logic [15:0] fill_cycles, bt_cycles;

  logic busy_t, done_t, fill_en_t, bt_en_t;
  logic [2:0] status_t;
  logic [6:0] result_len_t;
  logic [15:0] fill_cycles_t, bt_cycles_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  len;
    logic [15:0] fc;
    logic [15:0] bc;
  } res_t;

  res_t exp_q[$];
  int   pass_cnt = 0, total_cnt = 0, done_cnt = 0, inv_bad = 0;
  bit   bt_seen = 1'b0;

  always #5 clk = ~clk;

  bfs_solve_ctrl #(.CNT_W(16), .FILL_TMO(2048), .BT_TMO(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .status(status), .result_len(result_len), .fill_cycles(fill_cycles), .bt_cycles(bt_cycles),
    .fill_en(fill_en), .fill_done(fill_done), .fill_reached(fill_reached), .bt_en(bt_en),
    .bt_done(bt_done), .bt_no_path(bt_no_path), .bt_path_length(bt_path_length)
  );

  bfs_solve_ctrl #(.CNT_W(16), .FILL_TMO(8), .BT_TMO(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start_t), .abort(abort), .busy(busy_t), .done(done_t),
    .status(status_t), .result_len(result_len_t), .fill_cycles(fill_cycles_t), .bt_cycles(bt_cycles_t),
    .fill_en(fill_en_t), .fill_done(fill_done), .fill_reached(fill_reached), .bt_en(bt_en_t),
    .bt_done(bt_done), .bt_no_path(bt_no_path), .bt_path_length(bt_path_length)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bt_en) bt_seen = 1'b1;
    if ((bt_en && !fill_en) || (bt_en_t && !fill_en_t)) inv_bad++;
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_fill(input int n, input bit reached);
    repeat (n - 1) @(negedge clk);
    fill_done = 1'b1; fill_reached = reached;
    @(negedge clk);
    fill_done = 1'b0; fill_reached = 1'b0;
  endtask

  task automatic pulse_bt(input int n, input bit nop, input logic [6:0] len);
    repeat (n - 1) @(negedge clk);
    bt_done = 1'b1; bt_no_path = nop; bt_path_length = len;
    @(negedge clk);
    bt_done = 1'b0; bt_no_path = 1'b0; bt_path_length = '0;
  endtask

  task automatic wait_done(input bit sel, output bit got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if ((sel ? done_t : done) === 1'b1) begin
        got = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, status, result_len, fill_cycles, bt_cycles, fill_en, bt_en} !== '0)
      $display("FAIL reset_values: got busy=%b done=%b st=%0d len=%0d fc=%0d bc=%0d fe=%b be=%b want all 0",
               busy, done, status, result_len, fill_cycles, bt_cycles, fill_en, bt_en);
    else pass_cnt++;
    rst_n = 1'b1;
    do_start();
    pulse_fill(2, 1'b1);
    total_cnt++;
    if (bt_en !== 1'b1) $display("FAIL reset_pre_bt: got bt_en=%b want 1", bt_en);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({fill_en, bt_en, busy, status} !== 6'b0)
      $display("FAIL reset_mid_bt: got fe=%b be=%b busy=%b st=%0d want 0 0 0 0", fill_en, bt_en, busy, status);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_happy();
    bit got; res_t e;
    done_cnt = 0;
    exp_q.push_back('{3'd0, 7'd18, 16'd37, 16'd19});
    do_start();
    total_cnt++;
    if ({fill_en, bt_en, busy} !== 3'b101) $display("FAIL happy_fill_en: got fe=%b be=%b busy=%b want 1 0 1", fill_en, bt_en, busy);
    else pass_cnt++;
    pulse_fill(37, 1'b1);
    total_cnt++;
    if ({fill_en, bt_en, fill_cycles} !== {2'b11, 16'd37}) $display("FAIL happy_bt_entry: got fe=%b be=%b fc=%0d want 1 1 37", fill_en, bt_en, fill_cycles);
    else pass_cnt++;
    pulse_bt(19, 1'b0, 7'd18);
    total_cnt++;
    if ({fill_en, bt_en, busy, done} !== 4'b0010) $display("FAIL happy_clr: got fe=%b be=%b busy=%b done=%b want 0 0 1 0", fill_en, bt_en, busy, done);
    else pass_cnt++;
    wait_done(1'b0, got);
    total_cnt++;
    if (!got) $display("FAIL happy_done: got no done pulse want one");
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({status, result_len, fill_cycles, bt_cycles} !== e)
      $display("FAIL happy_result: got st=%0d len=%0d fc=%0d bc=%0d want st=%0d len=%0d fc=%0d bc=%0d",
               status, result_len, fill_cycles, bt_cycles, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if ({done, busy} !== 2'b00 || done_cnt != 1) $display("FAIL happy_single_done: got done=%b busy=%b pulses=%0d want 0 0 1", done, busy, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_unreachable();
    bit got; res_t e;
    bt_seen = 1'b0;
    exp_q.push_back('{3'd1, 7'd0, 16'd5, 16'd0});
    do_start();
    pulse_fill(5, 1'b0);
    wait_done(1'b0, got);
    total_cnt++;
    if (!got) $display("FAIL unreach_done: got no done pulse want one");
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({status, result_len, fill_cycles, bt_cycles} !== e)
      $display("FAIL unreach_result: got st=%0d len=%0d fc=%0d bc=%0d want st=%0d len=%0d fc=%0d bc=%0d",
               status, result_len, fill_cycles, bt_cycles, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
    total_cnt++;
    if (bt_seen !== 1'b0) $display("FAIL unreach_bt_en: got bt_en seen=%b want 0", bt_seen);
    else pass_cnt++;
  endtask

  task automatic test_bt_fail();
    bit got; res_t e;
    exp_q.push_back('{3'd1, 7'd0, 16'd3, 16'd7});
    do_start();
    pulse_fill(3, 1'b1);
    pulse_bt(7, 1'b1, 7'd55);
    wait_done(1'b0, got);
    total_cnt++;
    if (!got) $display("FAIL btfail_done: got no done pulse want one");
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({status, result_len, fill_cycles, bt_cycles} !== e)
      $display("FAIL btfail_result: got st=%0d len=%0d fc=%0d bc=%0d want st=%0d len=%0d fc=%0d bc=%0d",
               status, result_len, fill_cycles, bt_cycles, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit got; res_t e;
    exp_q.push_back('{3'd2, 7'd0, 16'd8, 16'd0});
    @(negedge clk); start_t = 1'b1;
    @(negedge clk); start_t = 1'b0;
    wait_done(1'b1, got);
    total_cnt++;
    if (!got) $display("FAIL tmo_fill_done: got no done pulse want one");
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({status_t, result_len_t, fill_cycles_t, bt_cycles_t} !== e)
      $display("FAIL tmo_fill_result: got st=%0d len=%0d fc=%0d bc=%0d want st=%0d len=%0d fc=%0d bc=%0d",
               status_t, result_len_t, fill_cycles_t, bt_cycles_t, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
    exp_q.push_back('{3'd3, 7'd0, 16'd1, 16'd4});
    @(negedge clk); start_t = 1'b1;
    @(negedge clk); start_t = 1'b0;
    pulse_fill(1, 1'b1);
    wait_done(1'b1, got);
    total_cnt++;
    if (!got) $display("FAIL tmo_bt_done: got no done pulse want one");
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({status_t, result_len_t, fill_cycles_t, bt_cycles_t} !== e)
      $display("FAIL tmo_bt_result: got st=%0d len=%0d fc=%0d bc=%0d want st=%0d len=%0d fc=%0d bc=%0d",
               status_t, result_len_t, fill_cycles_t, bt_cycles_t, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
  endtask

  task automatic test_abort_reentry();
    bit got; res_t e;
    // abort coincident with bt_done: completion wins
    exp_q.push_back('{3'd0, 7'd9, 16'd2, 16'd3});
    do_start();
    pulse_fill(2, 1'b1);
    repeat (2) @(negedge clk);
    bt_done = 1'b1; abort = 1'b1; bt_path_length = 7'd9;
    @(negedge clk);
    bt_done = 1'b0; abort = 1'b0; bt_path_length = '0;
    wait_done(1'b0, got);
    e = exp_q.pop_front();
    total_cnt++;
    if (!got || {status, result_len, fill_cycles, bt_cycles} !== e)
      $display("FAIL abort_vs_done: got done=%b st=%0d len=%0d fc=%0d bc=%0d want done=1 st=%0d len=%0d fc=%0d bc=%0d",
               got, status, result_len, fill_cycles, bt_cycles, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
    @(negedge clk);
    // abort alone in FILL, with a start while busy that must be ignored
    done_cnt = 0;
    exp_q.push_back('{3'd4, 7'd0, 16'd6, 16'd0});
    do_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(1'b0, got);
    e = exp_q.pop_front();
    total_cnt++;
    if (!got || {status, result_len, fill_cycles, bt_cycles} !== e)
      $display("FAIL abort_fill: got done=%b st=%0d len=%0d fc=%0d bc=%0d want done=1 st=%0d len=%0d fc=%0d bc=%0d",
               got, status, result_len, fill_cycles, bt_cycles, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
    repeat (4) @(negedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || done_cnt != 1) $display("FAIL start_while_busy: got busy=%b pulses=%0d want 0 1", busy, done_cnt);
    else pass_cnt++;
    // engine flags outside their phase are ignored
    @(negedge clk);
    fill_done = 1'b1; fill_reached = 1'b1; bt_done = 1'b1;
    repeat (3) @(negedge clk);
    fill_done = 1'b0; fill_reached = 1'b0; bt_done = 1'b0;
    @(negedge clk); #1;
    total_cnt++;
    if ({busy, fill_en, bt_en} !== 3'b000 || done_cnt != 1 || status !== 3'd4)
      $display("FAIL idle_flags: got busy=%b fe=%b be=%b pulses=%0d st=%0d want 0 0 0 1 4", busy, fill_en, bt_en, done_cnt, status);
    else pass_cnt++;
    // re-entry: results clear at accept
    exp_q.push_back('{3'd0, 7'd4, 16'd2, 16'd2});
    do_start();
    total_cnt++;
    if ({status, result_len, fill_cycles, bt_cycles} !== '0)
      $display("FAIL reentry_clear: got st=%0d len=%0d fc=%0d bc=%0d want all 0", status, result_len, fill_cycles, bt_cycles);
    else pass_cnt++;
    pulse_fill(2, 1'b1);
    pulse_bt(2, 1'b0, 7'd4);
    wait_done(1'b0, got);
    e = exp_q.pop_front();
    total_cnt++;
    if (!got || {status, result_len, fill_cycles, bt_cycles} !== e)
      $display("FAIL reentry_result: got done=%b st=%0d len=%0d fc=%0d bc=%0d want done=1 st=%0d len=%0d fc=%0d bc=%0d",
               got, status, result_len, fill_cycles, bt_cycles, e.st, e.len, e.fc, e.bc);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (inv_bad != 0) $display("FAIL bt_en_without_fill_en: got %0d cycles want 0", inv_bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_happy();
    test_unreachable();
    test_bt_fail();
    test_timeout();
    test_abort_reentry();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
